// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline datapath.
// The datapath (master) supplies stage information; the controller (slave) returns stall/flush controls.
interface pipeline_hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  // Stage information from the datapath
  logic              fwd_en;
  logic [3:0]        id_rn;
  logic [3:0]        id_rm;
  logic              id_use_rn;
  logic              id_use_rm;
  logic [3:0]        exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_read;
  logic [3:0]        mem_dest;
  logic              mem_wb_en;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;

  // Controls back to the datapath
  logic              freeze_if;
  logic              freeze_id;
  logic              bubble_id;
  logic              flush_if;
  logic              flush_id;
  logic              freeze_back;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles;
  logic              dbg_wait;      // 1 while the memory-wait FSM is in WAIT

  modport master (
    output fwd_en, id_rn, id_rm, id_use_rn, id_use_rm,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    input  freeze_if, freeze_id, bubble_id, flush_if, flush_id,
           freeze_back, mem_timeout, stall_cycles, dbg_wait
  );

  modport slave (
    input  fwd_en, id_rn, id_rm, id_use_rn, id_use_rm,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    output freeze_if, freeze_id, bubble_id, flush_if, flush_id,
           freeze_back, mem_timeout, stall_cycles, dbg_wait
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory stalls beat taken-branch flushes,
// which beat RAW hazard bubbles. Also tracks a sticky memory timeout and a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int PERF_W         = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  logic mem_stall;
  logic exe_match;
  logic mem_match;
  logic raw_hazard;
  logic flush_req;

  logic freeze_if, freeze_id, freeze_back, bubble_id, flush_if, flush_id;

  assign mem_stall = hz.mem_req & ~hz.mem_ready;

  assign exe_match = (hz.id_use_rn && (hz.id_rn == hz.exe_dest)) ||
                     (hz.id_use_rm && (hz.id_rm == hz.exe_dest));
  assign mem_match = (hz.id_use_rn && (hz.id_rn == hz.mem_dest)) ||
                     (hz.id_use_rm && (hz.id_rm == hz.mem_dest));

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw_hazard = hz.fwd_en ? (exe_match & hz.exe_wb_en & hz.exe_mem_read)
                                : ((exe_match & hz.exe_wb_en) | (mem_match & hz.mem_wb_en));

  // A branch seen during a memory stall is remembered and flushed once the stall clears.
  assign flush_req = (hz.branch_taken | flush_pend_q) & ~mem_stall;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != TIMEOUT_V) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    freeze_if   = 1'b0;
    freeze_id   = 1'b0;
    freeze_back = 1'b0;
    bubble_id   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        freeze_if   = 1'b1;
        freeze_id   = 1'b1;
        freeze_back = 1'b1;
      end else if (flush_req) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (raw_hazard) begin
        freeze_if = 1'b1;
        bubble_id = 1'b1;
      end
    end
  end

  always_comb begin
    flush_pend_d  = mem_stall ? (flush_pend_q | hz.branch_taken) : 1'b0;
    // Timeout is flagged as the counter reaches the limit, i.e. right after the N-th wait cycle.
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == TIMEOUT_V);
    stall_d       = stall_q;
    if (freeze_if && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      flush_pend_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_pend_q  <= flush_pend_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
    end
  end

  assign hz.freeze_if    = freeze_if;
  assign hz.freeze_id    = freeze_id;
  assign hz.freeze_back  = freeze_back;
  assign hz.bubble_id    = bubble_id;
  assign hz.flush_if     = flush_if;
  assign hz.flush_id     = flush_id;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cycles = stall_q;
  assign hz.dbg_wait     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus a small one
// (TIMEOUT_CYCLES=5, PERF_W=4) fed the same stimulus for timeout and saturation cases.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_hazard_ctrl_if #(.PERF_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.PERF_W(4))  bus_s ();

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(255), .CNT_W(8), .PERF_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(5), .CNT_W(8), .PERF_W(4)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .hz  (bus_s.slave)
  );

  assign bus_s.fwd_en       = bus.fwd_en;
  assign bus_s.id_rn        = bus.id_rn;
  assign bus_s.id_rm        = bus.id_rm;
  assign bus_s.id_use_rn    = bus.id_use_rn;
  assign bus_s.id_use_rm    = bus.id_use_rm;
  assign bus_s.exe_dest     = bus.exe_dest;
  assign bus_s.exe_wb_en    = bus.exe_wb_en;
  assign bus_s.exe_mem_read = bus.exe_mem_read;
  assign bus_s.mem_dest     = bus.mem_dest;
  assign bus_s.mem_wb_en    = bus.mem_wb_en;
  assign bus_s.branch_taken = bus.branch_taken;
  assign bus_s.mem_req      = bus.mem_req;
  assign bus_s.mem_ready    = bus.mem_ready;

  // {freeze_if, freeze_id, freeze_back, bubble_id, flush_if, flush_id}
  logic [5:0] ctl;
  assign ctl = {bus.freeze_if, bus.freeze_id, bus.freeze_back,
                bus.bubble_id, bus.flush_if, bus.flush_id};

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b111000;
  localparam logic [5:0] C_FLUSH = 6'b000011;
  localparam logic [5:0] C_HAZ   = 6'b100100;

  typedef struct {
    logic       fwd;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       urn;
    logic       urm;
    logic [3:0] ed;
    logic       ewb;
    logic       emr;
    logic [3:0] md;
    logic       mwb;
    logic       exp_haz;
  } raw_vec_t;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.fwd_en       = 1'b0;
    bus.id_rn        = 4'd0;
    bus.id_rm        = 4'd0;
    bus.id_use_rn    = 1'b0;
    bus.id_use_rm    = 1'b0;
    bus.exe_dest     = 4'd0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_read = 1'b0;
    bus.mem_dest     = 4'd0;
    bus.mem_wb_en    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic drive_hazard();
    bus.fwd_en    = 1'b0;
    bus.id_rn     = 4'd3;
    bus.id_use_rn = 1'b1;
    bus.exe_dest  = 4'd3;
    bus.exe_wb_en = 1'b1;
  endtask

  task automatic drive_raw(input raw_vec_t v);
    bus.fwd_en       = v.fwd;
    bus.id_rn        = v.rn;
    bus.id_rm        = v.rm;
    bus.id_use_rn    = v.urn;
    bus.id_use_rm    = v.urm;
    bus.exe_dest     = v.ed;
    bus.exe_wb_en    = v.ewb;
    bus.exe_mem_read = v.emr;
    bus.mem_dest     = v.md;
    bus.mem_wb_en    = v.mwb;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.fwd_en = 1'b0; bus.id_rn = 4'd1; bus.id_rm = 4'd1;
    bus.id_use_rn = 1'b1; bus.id_use_rm = 1'b1;
    bus.exe_dest = 4'd1; bus.exe_wb_en = 1'b1; bus.exe_mem_read = 1'b1;
    bus.mem_dest = 4'd1; bus.mem_wb_en = 1'b1; bus.branch_taken = 1'b1;
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (ctl !== C_NONE) begin
        bad++; $display("FAIL reset_ctl cyc%0d: got %b want %b", c, ctl, C_NONE);
      end
      tick();
    end
    total++;
    if (bus.stall_cycles !== 16'd0) begin
      bad++; $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles);
    end
    total++;
    if (bus.mem_timeout !== 1'b0 || bus_s.mem_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_timeout: got %b/%b want 0/0", bus.mem_timeout, bus_s.mem_timeout);
    end
    total++;
    if (bus.dbg_wait !== 1'b0) begin
      bad++; $display("FAIL reset_state: got %b want 0", bus.dbg_wait);
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== C_NONE) begin
      bad++; $display("FAIL post_reset_ctl: got %b want %b", ctl, C_NONE);
    end
    tick();
  endtask

  task automatic test_raw();
    raw_vec_t vecs[10];
    vecs[0] = '{1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 4'd0, 4'd7, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 4'd0, 4'd7, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 4'd5, 4'd9, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 4'd5, 4'd9, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 4'd5, 4'd9, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive_raw(vecs[i]);
      #1;
      total++;
      if (ctl !== (vecs[i].exp_haz ? C_HAZ : C_NONE)) begin
        bad++; $display("FAIL raw_vec%0d: got %b want %b", i, ctl, vecs[i].exp_haz ? C_HAZ : C_NONE);
      end
      tick();
    end
    clear_inputs();
    total++;
    if (bus.stall_cycles !== 16'd5) begin
      bad++; $display("FAIL raw_stall_cycles: got %0d want 5", bus.stall_cycles);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    drive_hazard();
    bus.branch_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_FLUSH) begin
      bad++; $display("FAIL branch_over_hazard: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    clear_inputs();
    bus.branch_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_FLUSH) begin
      bad++; $display("FAIL branch_alone: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    clear_inputs();
    total++;
    if (bus.stall_cycles !== 16'd0) begin
      bad++; $display("FAIL branch_stall_cycles: got %0d want 0", bus.stall_cycles);
    end
  endtask

  task automatic test_mem_branch();
    apply_reset();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.branch_taken = (c == 2);
      if (c == 3) drive_hazard();
      #1;
      total++;
      if (ctl !== C_STALL) begin
        bad++; $display("FAIL mem_stall_cyc%0d: got %b want %b", c, ctl, C_STALL);
      end
      tick();
      total++;
      if (bus.dbg_wait !== 1'b1) begin
        bad++; $display("FAIL mem_state_cyc%0d: got %b want 1", c, bus.dbg_wait);
      end
    end
    clear_inputs();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b1;
    drive_hazard();
    #1;
    total++;
    if (ctl !== C_FLUSH) begin
      bad++; $display("FAIL mem_pending_flush: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    total++;
    if (bus.stall_cycles !== 16'd4) begin
      bad++; $display("FAIL mem_stall_cycles: got %0d want 4", bus.stall_cycles);
    end
    total++;
    if (bus.dbg_wait !== 1'b0) begin
      bad++; $display("FAIL mem_state_idle: got %b want 0", bus.dbg_wait);
    end
    clear_inputs();
    #1;
    total++;
    if (ctl !== C_NONE) begin
      bad++; $display("FAIL mem_flush_once: got %b want %b", ctl, C_NONE);
    end
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (bus_s.mem_timeout !== (k >= 5)) begin
        bad++; $display("FAIL timeout_wait%0d: got %b want %b", k, bus_s.mem_timeout, (k >= 5));
      end
    end
    total++;
    if (bus.mem_timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_default_inst: got %b want 0", bus.mem_timeout);
    end
    bus.mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    tick();
    total++;
    if (bus_s.mem_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: got %b want 1", bus_s.mem_timeout);
    end
    apply_reset();
    total++;
    if (bus_s.mem_timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_cleared: got %b want 0", bus_s.mem_timeout);
    end
  endtask

  task automatic test_stall_sat();
    logic [3:0]  exp_s;
    logic [15:0] exp_l;
    apply_reset();
    drive_hazard();
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_s = (k >= 15) ? 4'd15 : 4'(k);
      exp_l = 16'(k);
      total++;
      if (bus_s.stall_cycles !== exp_s || bus.stall_cycles !== exp_l) begin
        bad++; $display("FAIL stall_sat_k%0d: got %0d/%0d want %0d/%0d",
                        k, bus_s.stall_cycles, bus.stall_cycles, exp_s, exp_l);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive_hazard();
    bus.branch_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_FLUSH) begin
      bad++; $display("FAIL b2b_flush: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    bus.branch_taken = 1'b0;
    #1;
    total++;
    if (ctl !== C_HAZ) begin
      bad++; $display("FAIL b2b_hazard: got %b want %b", ctl, C_HAZ);
    end
    tick();
    clear_inputs();
    bus.mem_req      = 1'b1;
    bus.branch_taken = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    #1;
    total++;
    if (ctl !== C_FLUSH) begin
      bad++; $display("FAIL b2b_held_branch: got %b want %b", ctl, C_FLUSH);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (ctl !== C_NONE) begin
      bad++; $display("FAIL b2b_after: got %b want %b", ctl, C_NONE);
    end
    total++;
    if (bus.stall_cycles !== 16'd3) begin
      bad++; $display("FAIL b2b_stall_cycles: got %0d want 3", bus.stall_cycles);
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clear_inputs();
    test_reset();
    test_raw();
    test_branch();
    test_mem_branch();
    test_timeout();
    test_stall_sat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
